// File: rtl/axi3_arbiter_2to1.sv
// axi3_arbiter_2to1: round-robin 2:1 AXI3 arbiter, independent read/write paths, one outstanding per path.
module axi3_arbiter_2to1 #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s0_arid,   s1_arid,
  input  logic [ADDR_W-1:0]   s0_araddr, s1_araddr,
  input  logic [3:0]          s0_arlen,  s1_arlen,
  input  logic [2:0]          s0_arsize, s1_arsize,
  input  logic [1:0]          s0_arburst, s1_arburst,
  input  logic [1:0]          s0_arlock, s1_arlock,
  input  logic [3:0]          s0_arcache, s1_arcache,
  input  logic [2:0]          s0_arprot, s1_arprot,
  input  logic                s0_arvalid, s1_arvalid,
  output logic                s0_arready, s1_arready,
  output logic [ID_W-1:0]     s0_rid,    s1_rid,
  output logic [DATA_W-1:0]   s0_rdata,  s1_rdata,
  output logic [1:0]          s0_rresp,  s1_rresp,
  output logic                s0_rlast,  s1_rlast,
  output logic                s0_rvalid, s1_rvalid,
  input  logic                s0_rready, s1_rready,
  input  logic [ID_W-1:0]     s0_awid,   s1_awid,
  input  logic [ADDR_W-1:0]   s0_awaddr, s1_awaddr,
  input  logic [3:0]          s0_awlen,  s1_awlen,
  input  logic [2:0]          s0_awsize, s1_awsize,
  input  logic [1:0]          s0_awburst, s1_awburst,
  input  logic [1:0]          s0_awlock, s1_awlock,
  input  logic [3:0]          s0_awcache, s1_awcache,
  input  logic [2:0]          s0_awprot, s1_awprot,
  input  logic                s0_awvalid, s1_awvalid,
  output logic                s0_awready, s1_awready,
  input  logic [ID_W-1:0]     s0_wid,    s1_wid,
  input  logic [DATA_W-1:0]   s0_wdata,  s1_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,  s1_wstrb,
  input  logic                s0_wlast,  s1_wlast,
  input  logic                s0_wvalid, s1_wvalid,
  output logic                s0_wready, s1_wready,
  output logic [ID_W-1:0]     s0_bid,    s1_bid,
  output logic [1:0]          s0_bresp,  s1_bresp,
  output logic                s0_bvalid, s1_bvalid,
  input  logic                s0_bready, s1_bready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [3:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [1:0]          m_arlock,
  output logic [3:0]          m_arcache,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [3:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [1:0]          m_awlock,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ID_W-1:0]     m_wid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);
  localparam int A_B = ID_W + ADDR_W + 18;
  localparam int R_B = ID_W + DATA_W + 3;
  localparam int W_B = ID_W + DATA_W + DATA_W/8 + 1;
  localparam int B_B = ID_W + 2;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_st_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_st_t;
  r_st_t r_st_q, r_st_d;
  w_st_t w_st_q, w_st_d;
  logic gr_q, gr_d, gw_q, gw_d, last_r_q, last_r_d, last_w_q, last_w_d;
  logic ar_ph, r_ph, aw_ph, w_ph, b_ph;
  logic [A_B-1:0] s0_ar, s1_ar, s0_aw, s1_aw;
  logic [W_B-1:0] s0_w, s1_w;
  logic [R_B-1:0] r_bus;
  logic [B_B-1:0] b_bus;
  assign s0_ar = {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot};
  assign s1_ar = {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot};
  assign s0_aw = {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache, s0_awprot};
  assign s1_aw = {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot};
  assign s0_w  = {s0_wid, s0_wdata, s0_wstrb, s0_wlast};
  assign s1_w  = {s1_wid, s1_wdata, s1_wstrb, s1_wlast};
  assign r_bus = {m_rid, m_rdata, m_rresp, m_rlast};
  assign b_bus = {m_bid, m_bresp};
  assign ar_ph = r_st_q == R_ADDR;
  assign r_ph  = r_st_q == R_DATA;
  assign aw_ph = w_st_q == W_ADDR;
  assign w_ph  = w_st_q == W_DATA;
  assign b_ph  = w_st_q == W_RESP;
  // Routing follows the registered grant; unrouted outputs are forced to zero.
  assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot} = ar_ph ? (gr_q ? s1_ar : s0_ar) : '0;
  assign m_arvalid  = ar_ph;
  assign s0_arready = ar_ph & ~gr_q & m_arready;
  assign s1_arready = ar_ph & gr_q & m_arready;
  assign {s0_rid, s0_rdata, s0_rresp, s0_rlast} = (r_ph & ~gr_q) ? r_bus : '0;
  assign {s1_rid, s1_rdata, s1_rresp, s1_rlast} = (r_ph & gr_q) ? r_bus : '0;
  assign s0_rvalid  = r_ph & ~gr_q & m_rvalid;
  assign s1_rvalid  = r_ph & gr_q & m_rvalid;
  assign m_rready   = r_ph & (gr_q ? s1_rready : s0_rready);
  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot} = aw_ph ? (gw_q ? s1_aw : s0_aw) : '0;
  assign m_awvalid  = aw_ph;
  assign s0_awready = aw_ph & ~gw_q & m_awready;
  assign s1_awready = aw_ph & gw_q & m_awready;
  assign {m_wid, m_wdata, m_wstrb, m_wlast} = w_ph ? (gw_q ? s1_w : s0_w) : '0;
  assign m_wvalid   = w_ph & (gw_q ? s1_wvalid : s0_wvalid);
  assign s0_wready  = w_ph & ~gw_q & m_wready;
  assign s1_wready  = w_ph & gw_q & m_wready;
  assign {s0_bid, s0_bresp} = (b_ph & ~gw_q) ? b_bus : '0;
  assign {s1_bid, s1_bresp} = (b_ph & gw_q) ? b_bus : '0;
  assign s0_bvalid  = b_ph & ~gw_q & m_bvalid;
  assign s1_bvalid  = b_ph & gw_q & m_bvalid;
  assign m_bready   = b_ph & (gw_q ? s1_bready : s0_bready);
  always_comb begin
    r_st_d   = r_st_q;
    gr_d     = gr_q;
    last_r_d = last_r_q;
    w_st_d   = w_st_q;
    gw_d     = gw_q;
    last_w_d = last_w_q;
    case (r_st_q)
      R_IDLE: if (s0_arvalid | s1_arvalid) begin
        r_st_d = R_ADDR;
        gr_d   = (s0_arvalid & s1_arvalid) ? ~last_r_q : s1_arvalid;
      end
      R_ADDR: if (m_arready) begin
        r_st_d   = R_DATA;
        last_r_d = gr_q;
      end
      R_DATA: if (m_rvalid & m_rready & m_rlast) r_st_d = R_IDLE;
      default: r_st_d = R_IDLE;
    endcase
    case (w_st_q)
      W_IDLE: if (s0_awvalid | s1_awvalid) begin
        w_st_d = W_ADDR;
        gw_d   = (s0_awvalid & s1_awvalid) ? ~last_w_q : s1_awvalid;
      end
      W_ADDR: if (m_awready) begin
        w_st_d   = W_DATA;
        last_w_d = gw_q;
      end
      W_DATA: if (m_wvalid & m_wready & m_wlast) w_st_d = W_RESP;
      W_RESP: if (m_bvalid & m_bready) w_st_d = W_IDLE;
      default: w_st_d = W_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_q   <= R_IDLE;
      w_st_q   <= W_IDLE;
      gr_q     <= 1'b0;
      gw_q     <= 1'b0;
      last_r_q <= 1'b1;
      last_w_q <= 1'b1;
    end else begin
      r_st_q   <= r_st_d;
      w_st_q   <= w_st_d;
      gr_q     <= gr_d;
      gw_q     <= gw_d;
      last_r_q <= last_r_d;
      last_w_q <= last_w_d;
    end
  end
endmodule

// File: tb/tb_axi3_arbiter_2to1.sv
// tb_axi3_arbiter_2to1: random two-master traffic against a transaction-level arbitration model.
module tb_axi3_arbiter_2to1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0]  s_arid[2], s_arlen[2], s_arcache[2], s_awid[2], s_awlen[2], s_awcache[2];
  logic [31:0] s_araddr[2], s_awaddr[2];
  logic [2:0]  s_arsize[2], s_arprot[2], s_awsize[2], s_awprot[2];
  logic [1:0]  s_arburst[2], s_arlock[2], s_awburst[2], s_awlock[2];
  logic        s_arvalid[2], s_arready[2], s_awvalid[2], s_awready[2];
  logic [3:0]  s_rid[2], s_wid[2], s_wstrb[2], s_bid[2];
  logic [31:0] s_rdata[2], s_wdata[2];
  logic [1:0]  s_rresp[2], s_bresp[2];
  logic        s_rlast[2], s_rvalid[2], s_rready[2];
  logic        s_wlast[2], s_wvalid[2], s_wready[2], s_bvalid[2], s_bready[2];
  logic [3:0]  m_arid, m_arlen, m_arcache, m_awid, m_awlen, m_awcache, m_rid, m_wid, m_wstrb, m_bid;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
  logic [1:0]  m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_awvalid, m_awready, m_rlast, m_rvalid, m_rready;
  logic        m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  axi3_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .s0_arid(s_arid[0]), .s1_arid(s_arid[1]), .s0_araddr(s_araddr[0]), .s1_araddr(s_araddr[1]),
    .s0_arlen(s_arlen[0]), .s1_arlen(s_arlen[1]), .s0_arsize(s_arsize[0]), .s1_arsize(s_arsize[1]),
    .s0_arburst(s_arburst[0]), .s1_arburst(s_arburst[1]), .s0_arlock(s_arlock[0]), .s1_arlock(s_arlock[1]),
    .s0_arcache(s_arcache[0]), .s1_arcache(s_arcache[1]), .s0_arprot(s_arprot[0]), .s1_arprot(s_arprot[1]),
    .s0_arvalid(s_arvalid[0]), .s1_arvalid(s_arvalid[1]), .s0_arready(s_arready[0]), .s1_arready(s_arready[1]),
    .s0_rid(s_rid[0]), .s1_rid(s_rid[1]), .s0_rdata(s_rdata[0]), .s1_rdata(s_rdata[1]),
    .s0_rresp(s_rresp[0]), .s1_rresp(s_rresp[1]), .s0_rlast(s_rlast[0]), .s1_rlast(s_rlast[1]),
    .s0_rvalid(s_rvalid[0]), .s1_rvalid(s_rvalid[1]), .s0_rready(s_rready[0]), .s1_rready(s_rready[1]),
    .s0_awid(s_awid[0]), .s1_awid(s_awid[1]), .s0_awaddr(s_awaddr[0]), .s1_awaddr(s_awaddr[1]),
    .s0_awlen(s_awlen[0]), .s1_awlen(s_awlen[1]), .s0_awsize(s_awsize[0]), .s1_awsize(s_awsize[1]),
    .s0_awburst(s_awburst[0]), .s1_awburst(s_awburst[1]), .s0_awlock(s_awlock[0]), .s1_awlock(s_awlock[1]),
    .s0_awcache(s_awcache[0]), .s1_awcache(s_awcache[1]), .s0_awprot(s_awprot[0]), .s1_awprot(s_awprot[1]),
    .s0_awvalid(s_awvalid[0]), .s1_awvalid(s_awvalid[1]), .s0_awready(s_awready[0]), .s1_awready(s_awready[1]),
    .s0_wid(s_wid[0]), .s1_wid(s_wid[1]), .s0_wdata(s_wdata[0]), .s1_wdata(s_wdata[1]),
    .s0_wstrb(s_wstrb[0]), .s1_wstrb(s_wstrb[1]), .s0_wlast(s_wlast[0]), .s1_wlast(s_wlast[1]),
    .s0_wvalid(s_wvalid[0]), .s1_wvalid(s_wvalid[1]), .s0_wready(s_wready[0]), .s1_wready(s_wready[1]),
    .s0_bid(s_bid[0]), .s1_bid(s_bid[1]), .s0_bresp(s_bresp[0]), .s1_bresp(s_bresp[1]),
    .s0_bvalid(s_bvalid[0]), .s1_bvalid(s_bvalid[1]), .s0_bready(s_bready[0]), .s1_bready(s_bready[1]),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rf(input logic [31:0] a, input int b);
    return ~a + 32'(b) * 32'h11;
  endfunction
  function automatic logic [31:0] wf(input logic [31:0] a, input int b);
    return a ^ (32'(b) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [53:0] arb(input int n);
    return {s_arid[n], s_araddr[n], s_arlen[n], s_arsize[n], s_arburst[n], s_arlock[n], s_arcache[n], s_arprot[n]};
  endfunction
  function automatic logic [53:0] awb(input int n);
    return {s_awid[n], s_awaddr[n], s_awlen[n], s_awsize[n], s_awburst[n], s_awlock[n], s_awcache[n], s_awprot[n]};
  endfunction

  // Reference: owner of each path (-1 = free), phase, and who was served last.
  int ro, wo, lr, lw, w_phase;
  bit r_adr;
  // Master agents: 0 idle, 1 requesting/sending, 2 awaiting data/response.
  int rm[2], rb[2], wm[2], wb[2], rdone[2], wdone[2];
  bit awp[2], won[2];
  // Slave agent.
  bit sr, srv, sbv;
  int sb, sr_len, sw, swb, sw_len, scnt_r, scnt_w;
  logic [3:0] sr_id, sw_id;
  logic [31:0] sr_a, sw_a;
  bit fresh, rst_done;
  int rst_cnt;

  task automatic reset_all();
    ro = -1; wo = -1; lr = 1; lw = 1; w_phase = 0; r_adr = 0;
    for (int n = 0; n < 2; n++) begin
      rm[n] = 0; rb[n] = 0; wm[n] = 0; wb[n] = 0; awp[n] = 0; won[n] = 0;
    end
    sr = 0; srv = 0; sbv = 0; sb = 0; sr_len = 0; sw = 0; swb = 0; sw_len = 0;
    fresh = 1;
  endtask

  task automatic drive(input bit go);
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) rst = 1'b0;
    end
    for (int n = 0; n < 2; n++) begin
      if (!rst && go && rm[n] == 0 && (fresh || $urandom % 4 == 0)) begin
        s_arid[n] = 4'($urandom); s_araddr[n] = $urandom; s_arlen[n] = 4'($urandom);
        s_arsize[n] = 3'($urandom); s_arburst[n] = 2'($urandom); s_arlock[n] = 2'($urandom);
        s_arcache[n] = 4'($urandom); s_arprot[n] = 3'($urandom);
        rm[n] = 1;
      end
      s_arvalid[n] = rm[n] == 1;
      s_rready[n] = $urandom % 4 != 0;
      if (!rst && go && wm[n] == 0 && (fresh || $urandom % 4 == 0)) begin
        s_awid[n] = 4'($urandom); s_awaddr[n] = $urandom; s_awlen[n] = 4'($urandom);
        s_awsize[n] = 3'($urandom); s_awburst[n] = 2'($urandom); s_awlock[n] = 2'($urandom);
        s_awcache[n] = 4'($urandom); s_awprot[n] = 3'($urandom);
        wm[n] = 1; awp[n] = 1; wb[n] = 0; won[n] = 1'($urandom);
      end else if (wm[n] == 1 && !won[n]) won[n] = 1'($urandom);
      s_awvalid[n] = awp[n];
      s_wvalid[n] = wm[n] == 1 && won[n];
      s_wid[n] = s_awid[n];
      s_wdata[n] = wf(s_awaddr[n], wb[n]);
      s_wstrb[n] = s_wdata[n][3:0];
      s_wlast[n] = wb[n] == int'(s_awlen[n]);
      s_bready[n] = $urandom % 4 != 0;
    end
    if (!rst) fresh = 0;
    m_arready = 1'($urandom); m_awready = 1'($urandom); m_wready = $urandom % 4 != 0;
    if (sr) begin
      if (!srv) srv = 1'($urandom);
      m_rvalid = srv; m_rid = sr_id; m_rdata = rf(sr_a, sb); m_rresp = 2'(sb); m_rlast = sb == sr_len;
    end else begin
      m_rvalid = $urandom % 8 == 0; m_rid = 4'($urandom); m_rdata = $urandom;
      m_rresp = 2'($urandom); m_rlast = 1'($urandom);
    end
    if (sw == 2) begin
      if (!sbv) sbv = 1'($urandom);
      m_bvalid = sbv; m_bid = sw_id; m_bresp = sw_id[1:0] ^ 2'b01;
    end else begin
      m_bvalid = $urandom % 8 == 0; m_bid = 4'($urandom); m_bresp = 2'($urandom);
    end
  endtask

  task automatic model_check();
    logic e_arv, e_rr, e_awv, e_wv, e_br;
    logic [1:0] e_ard, e_rv, e_awd, e_wd, e_bv;
    logic [53:0] e_ar, e_aw;
    logic [77:0] e_rb;
    logic [40:0] e_w;
    logic [11:0] e_b;
    bit rdat, wdat, bdat;
    int ri, wi;
    ri = ro < 0 ? 0 : ro;
    wi = wo < 0 ? 0 : wo;
    e_arv = ro >= 0 && r_adr;
    rdat = ro >= 0 && !r_adr;
    e_ar = e_arv ? arb(ri) : '0;
    e_ard = {e_arv && ri == 0 && m_arready, e_arv && ri == 1 && m_arready};
    e_rv = {rdat && ri == 0 && m_rvalid, rdat && ri == 1 && m_rvalid};
    e_rb = rdat ? (ri == 0 ? {m_rid, m_rdata, m_rresp, m_rlast, 39'b0} : {39'b0, m_rid, m_rdata, m_rresp, m_rlast}) : '0;
    e_rr = rdat && s_rready[ri];
    check("rd_ctl", {m_arvalid, s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1], m_rready}, {e_arv, e_ard, e_rv, e_rr});
    check("ar_bus", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}, e_ar);
    check("r_route", {s_rid[0], s_rdata[0], s_rresp[0], s_rlast[0], s_rid[1], s_rdata[1], s_rresp[1], s_rlast[1]}, e_rb);
    e_awv = wo >= 0 && w_phase == 0;
    wdat = wo >= 0 && w_phase == 1;
    bdat = wo >= 0 && w_phase == 2;
    e_aw = e_awv ? awb(wi) : '0;
    e_awd = {e_awv && wi == 0 && m_awready, e_awv && wi == 1 && m_awready};
    e_wd = {wdat && wi == 0 && m_wready, wdat && wi == 1 && m_wready};
    e_wv = wdat && s_wvalid[wi];
    e_w = wdat ? {s_wid[wi], s_wdata[wi], s_wstrb[wi], s_wlast[wi]} : '0;
    e_bv = {bdat && wi == 0 && m_bvalid, bdat && wi == 1 && m_bvalid};
    e_br = bdat && s_bready[wi];
    e_b = bdat ? (wi == 0 ? {m_bid, m_bresp, 6'b0} : {6'b0, m_bid, m_bresp}) : '0;
    check("wr_ctl", {m_awvalid, s_awready[0], s_awready[1], s_wready[0], s_wready[1], m_wvalid, s_bvalid[0], s_bvalid[1], m_bready},
          {e_awv, e_awd, e_wd, e_wv, e_bv, e_br});
    check("aw_bus", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot}, e_aw);
    check("w_bus", {m_wid, m_wdata, m_wstrb, m_wlast}, e_w);
    check("b_route", {s_bid[0], s_bresp[0], s_bid[1], s_bresp[1]}, e_b);
    if (rst) return;
    if (ro < 0) begin
      if (s_arvalid[0] || s_arvalid[1]) begin
        ro = (s_arvalid[0] && s_arvalid[1]) ? 1 - lr : (s_arvalid[1] ? 1 : 0);
        r_adr = 1;
      end
    end else if (r_adr) begin
      if (m_arready) begin r_adr = 0; lr = ro; end
    end else if (m_rvalid && e_rr && m_rlast) ro = -1;
    if (wo < 0) begin
      if (s_awvalid[0] || s_awvalid[1]) begin
        wo = (s_awvalid[0] && s_awvalid[1]) ? 1 - lw : (s_awvalid[1] ? 1 : 0);
        w_phase = 0;
      end
    end else if (w_phase == 0) begin
      if (m_awready) begin w_phase = 1; lw = wo; end
    end else if (w_phase == 1) begin
      if (e_wv && m_wready && s_wlast[wi]) w_phase = 2;
    end else if (m_bvalid && e_br) wo = -1;
  endtask

  task automatic agents();
    if (rst) return;
    for (int n = 0; n < 2; n++) begin
      if (s_arvalid[n] && s_arready[n]) begin rm[n] = 2; rb[n] = 0; end
      else if (rm[n] == 2 && s_rvalid[n] && s_rready[n]) begin
        check("r_data", {s_rid[n], s_rdata[n], s_rresp[n], s_rlast[n]},
              {s_arid[n], rf(s_araddr[n], rb[n]), 2'(rb[n]), rb[n] == int'(s_arlen[n])});
        if (rb[n] == int'(s_arlen[n])) begin rm[n] = 0; rdone[n]++; end
        else rb[n]++;
      end
      if (s_awvalid[n] && s_awready[n]) awp[n] = 0;
      if (s_wvalid[n] && s_wready[n]) begin
        won[n] = 0;
        if (s_wlast[n]) wm[n] = 2;
        else wb[n]++;
      end
      if (wm[n] == 2 && s_bvalid[n] && s_bready[n]) begin
        check("b_resp", {s_bid[n], s_bresp[n]}, {s_awid[n], s_awid[n][1:0] ^ 2'b01});
        wm[n] = 0; wdone[n]++;
      end
    end
    if (m_arvalid && m_arready) begin
      sr = 1; sr_id = m_arid; sr_a = m_araddr; sr_len = int'(m_arlen); sb = 0; srv = 0;
    end else if (sr && m_rvalid && m_rready) begin
      srv = 0;
      if (sb == sr_len) begin sr = 0; scnt_r++; end
      else sb++;
    end
    if (m_awvalid && m_awready) begin
      sw = 1; sw_id = m_awid; sw_a = m_awaddr; sw_len = int'(m_awlen); swb = 0;
    end else if (sw == 1 && m_wvalid && m_wready) begin
      logic [31:0] d;
      d = wf(sw_a, swb);
      check("w_data", {m_wid, m_wdata, m_wstrb, m_wlast}, {sw_id, d, d[3:0], swb == sw_len});
      if (swb == sw_len) begin sw = 2; sbv = 0; end
      else swb++;
    end else if (sw == 2 && m_bvalid && m_bready) begin
      sw = 0; scnt_w++;
    end
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      rdone[n] = 0; wdone[n] = 0;
      s_arid[n] = '0; s_araddr[n] = '0; s_arlen[n] = '0; s_arsize[n] = '0; s_arburst[n] = '0;
      s_arlock[n] = '0; s_arcache[n] = '0; s_arprot[n] = '0;
      s_awid[n] = '0; s_awaddr[n] = '0; s_awlen[n] = '0; s_awsize[n] = '0; s_awburst[n] = '0;
      s_awlock[n] = '0; s_awcache[n] = '0; s_awprot[n] = '0;
    end
    scnt_r = 0; scnt_w = 0; rst_done = 0; rst_cnt = 3;
    reset_all();
    for (int cyc = 0; cyc < 3400; cyc++) begin
      @(posedge clk);
      #1 drive(cyc < 3000);
      #1 model_check();
      agents();
      if (!rst && !rst_done && cyc >= 1200 && ((sr && sb == 1) || cyc >= 2000)) begin
        #1 rst = 1'b1;
        #1 check("rst_async", {m_arvalid, m_rready, s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1],
                               m_awvalid, m_wvalid, m_bready, s_awready[0], s_awready[1], s_wready[0], s_wready[1],
                               s_bvalid[0], s_bvalid[1]}, '0);
        reset_all();
        rst_cnt = 3; rst_done = 1;
      end
    end
    check("drained", {rm[0] == 0, rm[1] == 0, wm[0] == 0, wm[1] == 0, sr, sw == 0}, 6'b111101);
    check("rd_count", scnt_r, rdone[0] + rdone[1]);
    check("wr_count", scnt_w, wdone[0] + wdone[1]);
    check("all_served", {rdone[0] > 0, rdone[1] > 0, wdone[0] > 0, wdone[1] > 0, rst_done}, 5'h1F);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
